// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame feeder that sits in front of the
// 15-sample max/min tracker.
package frame_pkg;

    localparam int FRAME_LEN_DEF = 15;
    localparam int WIDTH_DEF     = 8;

    // IDLE: waiting for a full frame; STREAM: replaying one; GAP: one-cycle
    // valid-low separator so the tracker can reinitialise.
    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } feed_state_t;

    typedef logic [WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/frame_feeder_sync_fifo.sv
// Single-clock FIFO with registered occupancy. The read side exposes the head
// entry combinationally so the consumer can register it on the pop edge.
module sync_fifo
    import frame_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 32,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [LW-1:0]    level,
    output logic [WIDTH-1:0] head,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Storage write on every accepted push.
    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are valid, so clearing the data would just cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rptr];
    assign full = (level == LW'(DEPTH));

endmodule

// File: rtl/frame_feeder.sv
// Buffers a bursty sample stream and replays it in whole frames of FRAME_LEN
// contiguous valid cycles, with at least one valid-low cycle between frames.
module frame_feeder
    import frame_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DEPTH     = 32,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_num,
    output logic [LW-1:0]    level,
    output logic [7:0]       frames_out
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    feed_state_t      state;
    feed_state_t      state_next;
    logic [CW-1:0]    frame_cnt;
    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             fifo_flush;
    logic             last_pop;
    logic             frame_ready;

    // s_ready looks only at registered occupancy, so a pop never frees a slot
    // for a push in the same cycle.
    assign s_ready     = !fifo_full && !flush;
    assign push        = s_valid && s_ready;
    assign pop         = (state == STREAM);
    assign fifo_flush  = flush && (state == IDLE);
    assign last_pop    = pop && (frame_cnt == CW'(FRAME_LEN - 1));
    assign frame_ready = (level >= LW'(FRAME_LEN));

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (fifo_flush),
        .wdata (s_data),
        .level (level),
        .head  (head),
        .full  (fifo_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start only when a whole frame is resident, always pass
    // through GAP after the last sample of a frame.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (frame_ready && !flush) state_next = STREAM;
            STREAM:  if (last_pop)              state_next = GAP;
            GAP:     state_next = frame_ready ? STREAM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output registers, position within the frame and completed-frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_num    <= '0;
            frame_cnt  <= '0;
            frames_out <= '0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_num <= head;
            end
            if (last_pop) begin
                frame_cnt  <= '0;
                frames_out <= frames_out + 8'd1;
            end else if (pop) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_feeder.sv
// Self-checking bench for frame_feeder. The reference model is a queue of
// accepted samples; the output rules (whole resident frames, FRAME_LEN-long
// bursts, FIFO order, occupancy, s_ready) are checked against it every cycle.
module tb_frame_feeder;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 15;
    localparam int DEPTH     = 32;
    localparam int LW        = 6;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_num;
    logic [LW-1:0]    level;
    logic [7:0]       frames_out;

    frame_feeder #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .DEPTH     (DEPTH),
        .LW        (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_num    (out_num),
        .level      (level),
        .frames_out (frames_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    logic [WIDTH-1:0] exp_q[$];
    int run_len;
    int gap_len;
    int last_gap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model input side: record every accepted sample; a flush empties it.
    always @(posedge clk) begin
        if (rst_n) begin
            if (flush) exp_q.delete();
            else if (s_valid && s_ready) exp_q.push_back(s_data);
        end
    end

    // Model output side: compare each valid sample, burst length, occupancy and s_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            gap_len = 0;
        end else begin
            if (out_valid) begin
                if (run_len == 0) begin
                    check("frame_resident", 32'(exp_q.size() >= FRAME_LEN), 32'd1);
                    last_gap = gap_len;
                end
                if (exp_q.size() == 0) begin
                    check("out_underflow", 32'(out_num), 32'hFFFF_FFFF);
                end else begin
                    check("out_num", 32'(out_num), 32'(exp_q.pop_front()));
                end
                run_len++;
                gap_len = 0;
            end else begin
                if (run_len != 0) begin
                    check("burst_len", 32'(run_len), 32'(FRAME_LEN));
                    run_len = 0;
                end
                gap_len++;
            end
            check("level", 32'(level), 32'(exp_q.size()));
            check("s_ready", 32'(s_ready), 32'((exp_q.size() < DEPTH) && !flush));
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && guard < 200) begin
            sync();
            guard++;
        end
        if (guard >= 200) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        sync();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int guard = 0;
        while (quiet < 3 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (!out_valid && exp_q.size() < FRAME_LEN) quiet++;
            else quiet = 0;
        end
        if (guard >= 1000) check("idle_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic pulse_flush();
        sync();
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        sync();
        flush   = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        tests    = 0;
        fails    = 0;
        run_len  = 0;
        gap_len  = 0;
        last_gap = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        flush    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_num", 32'(out_num), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_frames_out", 32'(frames_out), 32'd0);

        // Single frame 10..24 and first-sample latency (two edges after the 15th accept).
        sync();
        for (int i = 10; i <= 24; i++) push(8'(i));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("first_latency", 32'(n), 32'd2);
        wait_idle();
        check("single_frames_out", 32'(frames_out), 32'd1);
        check("single_level", 32'(level), 32'd0);

        // Back-to-back frames 0..29 separated by exactly one valid-low cycle.
        sync();
        for (int i = 0; i < 30; i++) push(8'(i));
        wait_idle();
        check("b2b_gap", 32'(last_gap), 32'd1);
        check("b2b_frames_out", 32'(frames_out), 32'd3);

        // Gapped input still yields one contiguous burst.
        sync();
        for (int i = 0; i < FRAME_LEN; i++) begin
            repeat ($urandom_range(0, 3)) sync();
            push(8'($urandom));
        end
        wait_idle();
        check("gapped_frames_out", 32'(frames_out), 32'd4);

        // 100 samples at full rate: six frames out, ten left resident.
        sync();
        for (int i = 0; i < 100; i++) push(8'($urandom));
        wait_idle();
        check("bp_frames_out", 32'(frames_out), 32'd10);
        check("bp_level", 32'(level), 32'd10);

        // Flush in IDLE discards the leftovers and a partial frame.
        pulse_flush();
        check("flush_leftover_level", 32'(level), 32'd0);
        for (int i = 0; i < 7; i++) push(8'(100 + i));
        pulse_flush();
        check("flush_partial_level", 32'(level), 32'd0);
        repeat (20) sync();
        check("flush_no_frame", 32'(frames_out), 32'd10);
        for (int i = 0; i < FRAME_LEN; i++) push(8'(200 + i));
        wait_idle();
        check("flush_new_frame", 32'(frames_out), 32'd11);

        // Reset during the 5th valid cycle of a frame.
        sync();
        for (int i = 0; i < FRAME_LEN; i++) push(8'($urandom));
        n = 0;
        guard = 0;
        while (n < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (out_valid) n++;
        end
        check("midrst_reached", 32'(n), 32'd5);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_num", 32'(out_num), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_frames_out", 32'(frames_out), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        sync();
        for (int i = 0; i < FRAME_LEN; i++) push(8'(50 + i));
        wait_idle();
        check("post_rst_frames_out", 32'(frames_out), 32'd1);
        check("post_rst_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
